usb_tx_controller: RTL
======================

# usb_tx_controller

Device-side USB full-speed packet transmitter. It accepts one-cycle-sampled commands from the USB master controller (tx_send_good, tx_send_bad, tx_transmit) and builds the packet: ACK/NAK handshake, or DATA0/DATA1 with a payload read from the SD-to-USB byte FIFO plus CRC16. It serialises the packet with bit stuffing and NRZI onto D+/D−, then reports tx_done or tx_err back to the controller.

## Interface
- CLKS_PER_BIT, 8, clk cycles per USB bit time (96 MHz clk → 12 Mb/s).
- MAX_BYTES, 64, maximum payload bytes per data packet.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- tx_send_good  in  1  request ACK handshake.
- tx_send_bad  in  1  request NAK handshake.
- tx_transmit  in  1  request data packet.
- data_pid_sel  in  1  0 = DATA0, 1 = DATA1; sampled with the command.
- byte_count  in  7  payload length, 0..MAX_BYTES; sampled with the command.
- fifo_rdata  in  8  show-ahead FIFO head byte; valid when fifo_empty = 0.
- fifo_empty  in  1  FIFO has no byte.
- fifo_read  out  1  one-cycle pop strobe.
- dplus_out  out  1  D+ line.
- dminus_out  out  1  D− line.
- tx_busy  out  1  high from command acceptance through the end of EOP.
- tx_done  out  1  one-cycle pulse: packet sent cleanly.
- tx_err  out  1  one-cycle pulse: packet aborted or rejected.

## Operation
- Reset values: dplus_out = 1 and dminus_out = 0 (idle J); every other output is 0. The state register goes to IDLE.
- Commands are sampled only in IDLE and are ignored while busy. They are level-tolerant.
  - Priority: tx_send_bad > tx_send_good > tx_transmit.
- byte_count > MAX_BYTES on tx_transmit: no bus activity; pulse tx_err on the next cycle; stay in IDLE.
- PID byte is {~pid, pid}, sent LSB first:
  - ACK = 0xD2
  - NAK = 0x5A
  - DATA0 = 0xC3
  - DATA1 = 0x4B
- FSM states: IDLE → LOAD → SYNC → PID → (handshake: EOP_SE0) or (data: DATA → CRC → EOP_SE0) → EOP_J → DONE → IDLE.
  - DATA is skipped when byte_count = 0.
- SYNC is 0x80, sent LSB first (KJKJKJKK).
- CRC16:
  - Polynomial 0x8005, register initialised to 0xFFFF in LOAD.
  - Updated over payload bits LSB first.
  - Transmitted as the complemented register, bit 15 first.
- NRZI: a 0 bit toggles the line; a 1 bit holds the line.
- Bit stuffing:
  - After 6 consecutive 1s, insert a 0. This applies through SYNC, PID, DATA and CRC.
  - The ones counter starts at 0 in LOAD.
  - A stuff bit that falls due after the last CRC bit is still sent before EOP.
- EOP: SE0 (both lines 0) for 2 bit times, then J for 1 bit time. DONE then pulses tx_done or tx_err.
- FIFO underflow (fifo_empty = 1 when a payload byte is needed): abort the rest of DATA/CRC, go to EOP_SE0 immediately, and pulse tx_err instead of tx_done in DONE.
- Reset mid-packet: lines return to J asynchronously and no tx_done/tx_err is issued.

## Timing
- Command seen in IDLE at cycle t: LOAD at t+1. tx_busy and the first SYNC bit are driven from t+2.
- Each bit, including stuff bits, is held exactly CLKS_PER_BIT cycles. Line transitions occur only at bit-timer wrap.
- fifo_read pulses for one cycle at the start of the last bit of the preceding field. The next byte is loaded into the shift register at the byte boundary.
  - Exactly byte_count pops per packet, or fewer on underflow.
- Packet lengths, excluding stuff bits:
  - Handshake: 8 + 8 + 3 = 19 bit times.
  - Data packet: 8 + 8 + 8·n + 16 + 3 bit times.
- tx_done/tx_err are high for 1 cycle, in the cycle after EOP_J ends. tx_busy falls in that same cycle.
- tx_done and tx_err are never asserted together.

## Structure
- Shared package usb_pkg holds the PID constants (ACK, NAK, DATA0, DATA1), SYNC_BYTE, CRC16_POLY, CRC16_INIT and the transmitter state enum.
- Sub-module usb_bit_encoder owns the bit timer, the NRZI line state and the stuff counter.
  - It presents bit_in, bit_valid, bit_taken and se0 to the packet FSM.
  - It stalls the FSM (no bit_taken) during a stuff bit.

## Test plan
- tx_send_good pulse → line decodes to SYNC, PID 0xD2, EOP; tx_done after 19 bit times + 2 cycles; no fifo_read.
- tx_send_bad and tx_transmit high together → NAK 0x5A sent; no fifo_read; tx_done.
- tx_transmit, data_pid_sel = 1, byte_count = 0 → PID 0x4B, CRC field 0x0000, EOP; tx_done.
- tx_transmit, byte_count = 2, FIFO = 0xFF, 0xFF → stuff bits inserted after every 6 ones; decoded payload 0xFF 0xFF; CRC matches the model; exactly 2 fifo_read pulses.
- tx_transmit, byte_count = 4, FIFO holds 2 bytes → 2 pops, early EOP, tx_err pulse, no tx_done.
- byte_count = 65 → tx_err one cycle later, lines stay J. Separately, n_rst asserted mid-DATA → lines J, tx_busy 0, no pulses.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants, state encoding and CRC helper for the USB full-speed transmitter.
package usb_pkg;

    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_DATA1  = 8'h4B;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SYNC,
        PID,
        DATA,
        CRC,
        EOP_SE0,
        EOP_J,
        DONE
    } tx_state_e;

    // One payload bit into the CRC16 register, shift-left form.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        crc16_step = {crc[14:0], 1'b0} ^ ((b ^ crc[15]) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_bit_encoder.sv
// Bit-time generator: down-counting bit timer, NRZI line state and bit stuffing.
// The packet FSM offers one symbol per bit time; a stuff bit withholds bit_taken.
module usb_bit_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_ones,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic se0,
    input  logic force_j,
    output logic bit_taken,
    output logic bit_tick,
    output logic dplus,
    output logic dminus
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    ones_q, ones_d, ones_base;
    logic          dp_q, dp_d, dm_q, dm_d;
    logic          stuff_due;

    assign bit_tick  = (timer_q == '0);
    assign ones_base = clear_ones ? 3'd0 : ones_q;
    assign stuff_due = (ones_base == 3'd6);
    assign bit_taken = bit_tick && bit_valid && !stuff_due;
    assign dplus     = dp_q;
    assign dminus    = dm_q;

    always_comb begin
        timer_d = timer_q;
        ones_d  = ones_base;
        dp_d    = dp_q;
        dm_d    = dm_q;
        if (!bit_tick) begin
            timer_d = timer_q - TW'(1);
        end else if (stuff_due) begin
            timer_d = TIMER_RELOAD;
            ones_d  = 3'd0;
            dp_d    = dm_q;
            dm_d    = dp_q;
        end else if (bit_valid) begin
            timer_d = TIMER_RELOAD;
            if (se0) begin
                dp_d   = 1'b0;
                dm_d   = 1'b0;
                ones_d = 3'd0;
            end else if (force_j) begin
                dp_d   = 1'b1;
                dm_d   = 1'b0;
                ones_d = 3'd0;
            end else if (bit_in) begin
                ones_d = ones_base + 3'd1;
            end else begin
                dp_d   = dm_q;
                dm_d   = dp_q;
                ones_d = 3'd0;
            end
        end else begin
            // Nothing offered: park the bus in J with the timer held at zero.
            dp_d   = 1'b1;
            dm_d   = 1'b0;
            ones_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q <= '0;
            ones_q  <= 3'd0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
        end else begin
            timer_q <= timer_d;
            ones_q  <= ones_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
        end
    end

endmodule

// File: rtl/usb_tx_controller.sv
// Device-side USB full-speed packet transmitter: handshake or DATA0/1 + CRC16.
//   state   | meaning
//   IDLE    | bus J, waiting for a command
//   LOAD    | init CRC and stuff counter, offer first SYNC bit
//   SYNC    | remaining SYNC bits
//   PID     | PID byte, LSB first
//   DATA    | payload bytes from FIFO
//   CRC     | complemented CRC16, bit 15 first
//   EOP_SE0 | two SE0 bit times
//   EOP_J   | one J bit time, then wait for it to finish
//   DONE    | tx_done or tx_err pulse
module usb_tx_controller
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_send_good,
    input  logic       tx_send_bad,
    input  logic       tx_transmit,
    input  logic       data_pid_sel,
    input  logic [6:0] byte_count,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    tx_state_e   state_q;
    logic [3:0]  bit_idx_q;
    logic [7:0]  pid_q;
    logic [7:0]  shift_q;
    logic [15:0] crc_q;
    logic [6:0]  len_q;
    logic [6:0]  bytes_left_q;
    logic        is_data_q;
    logic        abort_q;
    logic        fifo_read_q;
    logic        tx_busy_q;
    logic        tx_done_q;
    logic        tx_err_q;

    logic bit_in, bit_valid, se0, force_j, bit_taken, bit_tick;

    usb_bit_encoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_enc (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_ones (state_q == LOAD),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .se0        (se0),
        .force_j    (force_j),
        .bit_taken  (bit_taken),
        .bit_tick   (bit_tick),
        .dplus      (dplus_out),
        .dminus     (dminus_out)
    );

    // Symbol offered to the encoder for the next bit time.
    always_comb begin
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        se0       = 1'b0;
        force_j   = 1'b0;
        case (state_q)
            LOAD: begin
                bit_in    = SYNC_BYTE[0];
                bit_valid = 1'b1;
            end
            SYNC: begin
                bit_in    = SYNC_BYTE[bit_idx_q[2:0]];
                bit_valid = 1'b1;
            end
            PID: begin
                bit_in    = pid_q[bit_idx_q[2:0]];
                bit_valid = 1'b1;
            end
            DATA: begin
                bit_in    = shift_q[0];
                bit_valid = 1'b1;
            end
            CRC: begin
                bit_in    = ~crc_q[15];
                bit_valid = 1'b1;
            end
            EOP_SE0: begin
                se0       = 1'b1;
                bit_valid = 1'b1;
            end
            EOP_J: begin
                force_j   = 1'b1;
                bit_valid = (bit_idx_q == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= 4'd0;
            pid_q        <= 8'h00;
            shift_q      <= 8'h00;
            crc_q        <= CRC16_INIT;
            len_q        <= 7'd0;
            bytes_left_q <= 7'd0;
            is_data_q    <= 1'b0;
            abort_q      <= 1'b0;
            fifo_read_q  <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
        end else begin
            fifo_read_q <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_idx_q <= 4'd0;
                    if (tx_send_bad) begin
                        pid_q     <= PID_NAK;
                        is_data_q <= 1'b0;
                        state_q   <= LOAD;
                    end else if (tx_send_good) begin
                        pid_q     <= PID_ACK;
                        is_data_q <= 1'b0;
                        state_q   <= LOAD;
                    end else if (tx_transmit) begin
                        if (byte_count > 7'(MAX_BYTES)) begin
                            tx_err_q <= 1'b1;
                        end else begin
                            pid_q     <= data_pid_sel ? PID_DATA1 : PID_DATA0;
                            len_q     <= byte_count;
                            is_data_q <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    crc_q     <= CRC16_INIT;
                    abort_q   <= 1'b0;
                    tx_busy_q <= 1'b1;
                    if (bit_taken) begin
                        bit_idx_q <= 4'd1;
                        state_q   <= SYNC;
                    end
                end
                SYNC: begin
                    if (bit_taken) begin
                        if (bit_idx_q == 4'd7) begin
                            bit_idx_q <= 4'd0;
                            state_q   <= PID;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                PID: begin
                    if (bit_taken) begin
                        if (bit_idx_q == 4'd7) begin
                            bit_idx_q <= 4'd0;
                            if (!is_data_q) begin
                                state_q <= EOP_SE0;
                            end else if (len_q == 7'd0) begin
                                state_q <= CRC;
                            end else if (fifo_empty) begin
                                abort_q <= 1'b1;
                                state_q <= EOP_SE0;
                            end else begin
                                shift_q      <= fifo_rdata;
                                fifo_read_q  <= 1'b1;
                                bytes_left_q <= len_q - 7'd1;
                                state_q      <= DATA;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (bit_taken) begin
                        crc_q   <= crc16_step(crc_q, shift_q[0]);
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 4'd7) begin
                            bit_idx_q <= 4'd0;
                            if (bytes_left_q == 7'd0) begin
                                state_q <= CRC;
                            end else if (fifo_empty) begin
                                abort_q <= 1'b1;
                                state_q <= EOP_SE0;
                            end else begin
                                shift_q      <= fifo_rdata;
                                fifo_read_q  <= 1'b1;
                                bytes_left_q <= bytes_left_q - 7'd1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                CRC: begin
                    if (bit_taken) begin
                        crc_q <= {crc_q[14:0], 1'b0};
                        if (bit_idx_q == 4'd15) begin
                            bit_idx_q <= 4'd0;
                            state_q   <= EOP_SE0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                EOP_SE0: begin
                    if (bit_taken) begin
                        if (bit_idx_q == 4'd1) begin
                            bit_idx_q <= 4'd0;
                            state_q   <= EOP_J;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                EOP_J: begin
                    // idx 0: J offered; idx 1: wait until the J bit time has elapsed.
                    if (bit_idx_q == 4'd0) begin
                        if (bit_taken) begin
                            bit_idx_q <= 4'd1;
                        end
                    end else if (bit_tick) begin
                        bit_idx_q <= 4'd0;
                        tx_busy_q <= 1'b0;
                        tx_done_q <= !abort_q;
                        tx_err_q  <= abort_q;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    bit_idx_q <= 4'd0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_read = fifo_read_q;
    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;
    assign tx_err    = tx_err_q;

endmodule
